// File: rtl/edge_pkg.sv
// edge_pkg: shared classification/FSM types and index-width helper for edge_hysteresis.
package edge_pkg;
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } edge_class_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int IMG_W_DEF = 448;
    localparam int COL_W     = $clog2(IMG_W_DEF);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/edge_line_flags.sv
// edge_line_flags: one edge bit per column from the previous row; sync write, comb read, no reset.
module edge_line_flags #(
    parameter int W  = 448,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);
    logic mem_q [W];

    always_ff @(posedge clk)
        if (we_i) mem_q[addr_i] <= wdata_i;

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/edge_hysteresis.sv
// edge_hysteresis: threshold classification plus single-pass causal hysteresis on a gradient stream.
// Define EDGE_BORDER_CLR_EN to force edge = 0 on the image border.
module edge_hysteresis
    import edge_pkg::*;
#(
    parameter int IMG_W = 448,
    parameter int IMG_H = 448,
    parameter int MAG_W = 16,
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic             chl_x_i,
    input  logic             chl_y_i,
    input  logic [MAG_W-1:0] thr_hi_i,
    input  logic [MAG_W-1:0] thr_lo_i,
    output logic             out_valid_o,
    output logic             edge_o,
    output logic [1:0]       edge_class_o,
    output logic [1:0]       dir_o,
    output logic [CNT_W-1:0] edge_count_o,
    output logic             frame_done_o,
    output logic             busy_o
);
    localparam int CW = idx_w(IMG_W);
    localparam int RW = idx_w(IMG_H);

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col1_q;
    logic [RW-1:0]    row_q;
    logic [MAG_W-1:0] thr_hi_q, thr_lo_q, thr_hi, thr_lo;
    logic             start, col_end, last;
    logic             v1_q, first1_q, last1_q, row0_1_q;
    logic [1:0]       dir1_q, dir_q;
    edge_class_t      cls_d, cls1_q, cls_q;
    logic             above_flag, left, above, keep, edge_d;
    logic             out_valid_q, edge_q, frame_done_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else state_q <= state_d;

    always_comb state_d = in_valid_i ? (last ? ST_IDLE : ST_RUN) : state_q;

    always_comb busy_o = state_q == ST_RUN;

    assign start   = state_q == ST_IDLE && in_valid_i;
    assign col_end = col_q == CW'(IMG_W - 1);
    assign last    = col_end && row_q == RW'(IMG_H - 1);
    // The first pixel is classified against the thresholds being latched alongside it
    assign thr_hi  = start ? thr_hi_i : thr_hi_q;
    assign thr_lo  = start ? thr_lo_i : thr_lo_q;
    assign cls_d   = mag_i >= thr_hi ? CLS_STRONG : mag_i >= thr_lo ? CLS_WEAK : CLS_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            thr_hi_q <= '0;
            thr_lo_q <= '0;
            v1_q     <= 1'b0;
            col1_q   <= '0;
            cls1_q   <= CLS_NONE;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            row0_1_q <= 1'b0;
            dir1_q   <= '0;
        end else begin
            v1_q <= in_valid_i;
            if (start) begin
                thr_hi_q <= thr_hi_i;
                thr_lo_q <= thr_lo_i;
            end
            if (in_valid_i) begin
                col_q    <= col_end ? '0 : col_q + CW'(1);
                row_q    <= last ? '0 : row_q + RW'(col_end);
                col1_q   <= col_q;
                cls1_q   <= cls_d;
                first1_q <= start;
                last1_q  <= last;
                row0_1_q <= row_q == '0;
                dir1_q   <= {chl_y_i, chl_x_i};
            end
        end
    end

`ifdef EDGE_BORDER_CLR_EN
    logic b1_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) b1_q <= 1'b0;
        else if (in_valid_i) b1_q <= col_q == '0 || col_end || row_q == '0 || row_q == RW'(IMG_H - 1);

    assign keep = !b1_q;
`else
    assign keep = 1'b1;
`endif

    // edge_q still holds the previous output's decision, which is the left neighbour
    assign left   = col1_q != '0 && edge_q;
    assign above  = !row0_1_q && above_flag;
    assign edge_d = keep && (cls1_q == CLS_STRONG || (cls1_q == CLS_WEAK && (left || above)));

    edge_line_flags #(.W(IMG_W), .AW(CW)) u_flags (
        .clk     (clk),
        .we_i    (v1_q),
        .addr_i  (col1_q),
        .wdata_i (edge_d),
        .rdata_o (above_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            edge_q       <= 1'b0;
            cls_q        <= CLS_NONE;
            dir_q        <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= v1_q;
            frame_done_q <= v1_q && last1_q;
            if (v1_q) begin
                edge_q <= edge_d;
                cls_q  <= cls1_q;
                dir_q  <= dir1_q;
                cnt_q  <= first1_q ? CNT_W'(edge_d) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(edge_d));
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign edge_o       = edge_q;
    assign edge_class_o = cls_q;
    assign dir_o        = dir_q;
    assign edge_count_o = cnt_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_edge_hysteresis.sv
// tb_edge_hysteresis: table-driven directed vectors for edge_hysteresis on a 4x3 image.
module tb_edge_hysteresis;
    import edge_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int NPIX = W * H;
`ifdef EDGE_BORDER_CLR_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [15:0] mag_i = '0;
    logic        chl_x_i = 1'b0;
    logic        chl_y_i = 1'b0;
    logic [15:0] thr_hi_i = '0;
    logic [15:0] thr_lo_i = '0;
    logic        out_valid_o, edge_o, frame_done_o, busy_o;
    logic [1:0]  edge_class_o, dir_o;
    logic [17:0] edge_count_o;

    always #5 clk = ~clk;

    edge_hysteresis #(.IMG_W(W), .IMG_H(H), .MAG_W(16), .CNT_W(18)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .mag_i        (mag_i),
        .chl_x_i      (chl_x_i),
        .chl_y_i      (chl_y_i),
        .thr_hi_i     (thr_hi_i),
        .thr_lo_i     (thr_lo_i),
        .out_valid_o  (out_valid_o),
        .edge_o       (edge_o),
        .edge_class_o (edge_class_o),
        .dir_o        (dir_o),
        .edge_count_o (edge_count_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic        v;
        logic [15:0] mag, hi, lo;
        logic [1:0]  dir;
        logic        e;
        edge_class_t cls;
        logic        first, last;
    } vec_t;

    vec_t        vecs[$];
    vec_t        prev;
    int          n_vec = 0;
    int          n_err = 0;
    int          pix = 0;
    logic [17:0] cnt_m = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input int mag, input int hi, input int lo, input logic e, input edge_class_t cls);
        vec_t r;
        r.v = v;
        r.mag = 16'(mag);
        r.hi = 16'(hi);
        r.lo = 16'(lo);
        r.dir = 2'(vecs.size());
        r.e = e;
        r.cls = cls;
        r.first = 1'b0;
        r.last = 1'b0;
        vecs.push_back(r);
    endtask

    task automatic check();
        cmp("out_valid", out_valid_o, prev.v);
        if (prev.v) begin
            cnt_m = prev.first ? 18'(prev.e) : cnt_m + 18'(prev.e);
            cmp("edge", edge_o, prev.e);
            cmp("edge_class", edge_class_o, prev.cls);
            cmp("dir", dir_o, prev.dir);
        end
        cmp("edge_count", edge_count_o, cnt_m);
        cmp("frame_done", frame_done_o, prev.v && prev.last);
    endtask

    task automatic step(input vec_t r);
        vec_t a;
        a = r;
        in_valid_i = r.v;
        mag_i = r.mag;
        thr_hi_i = r.hi;
        thr_lo_i = r.lo;
        {chl_y_i, chl_x_i} = r.dir;
        @(posedge clk);
        #1;
        check();
        if (r.v) begin
            a.first = pix == 0;
            a.last = pix == NPIX - 1;
            pix = (pix == NPIX - 1) ? 0 : pix + 1;
            cmp("busy", busy_o, !a.last);
        end
        prev = a;
    endtask

    task automatic run_table();
        foreach (vecs[i]) step(vecs[i]);
        vecs.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 2; i++) add(1'b0, 16'hFFFF, 0, 0, 1'b0, CLS_NONE);
        run_table();
    endtask

    task automatic reset_chk();
        cmp("rst_out_valid", out_valid_o, 0);
        cmp("rst_edge", edge_o, 0);
        cmp("rst_edge_class", edge_class_o, 0);
        cmp("rst_dir", dir_o, 0);
        cmp("rst_edge_count", edge_count_o, 0);
        cmp("rst_frame_done", frame_done_o, 0);
        cmp("rst_busy", busy_o, 0);
    endtask

    task automatic model_reset();
        prev.v = 1'b0;
        prev.first = 1'b0;
        prev.last = 1'b0;
        pix = 0;
        cnt_m = '0;
    endtask

    task automatic frame_mixed();
        add(1, 120, 100, 50, 1, CLS_STRONG);
        add(1, 60, 100, 50, 1, CLS_WEAK);
        add(1, 60, 100, 50, 1, CLS_WEAK);
        add(1, 10, 100, 50, 0, CLS_NONE);
        for (int i = 0; i < 8; i++) add(1, 60, 100, 50, 1, CLS_WEAK);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_chk();
        rst_n = 1'b1;
`ifndef EDGE_BORDER_CLR_EN
        for (int i = 0; i < NPIX; i++) add(1, 120, 100, 50, 1, CLS_STRONG);
        run_table();
        drain();
        cmp("t1_count", edge_count_o, 12);

        frame_mixed();
        run_table();
        drain();
        cmp("t2_count", edge_count_o, 11);

        add(1, 40, 100, 50, 0, CLS_NONE);
        for (int i = 1; i < NPIX; i++) add(1, 60, 100, 50, 0, CLS_WEAK);
        run_table();
        drain();
        cmp("t3_count", edge_count_o, 0);

        add(1, 150, 100, 200, 1, CLS_STRONG);
        add(1, 90, 100, 200, 0, CLS_NONE);
        for (int i = 2; i < NPIX; i++) add(1, 90, 10, 200, 0, CLS_NONE);
        run_table();
        add(1, 90, 10, 5, 1, CLS_STRONG);
        for (int i = 1; i < NPIX; i++) begin
            add(0, 16'hFFFF, 16'hFFFF, 0, 0, CLS_NONE);
            add(0, 16'hFFFF, 16'hFFFF, 0, 0, CLS_NONE);
            add(1, 90, 1000, 5, 1, CLS_STRONG);
        end
        run_table();
        drain();
        cmp("t5_count", edge_count_o, 12);
`endif
        for (int i = 0; i < 5; i++) add(1, 120, 100, 50, !BORDER, CLS_STRONG);
        run_table();
        in_valid_i = 1'b1;
        mag_i = 16'd120;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        reset_chk();
        rst_n = 1'b1;
        in_valid_i = 1'b0;
        model_reset();
`ifndef EDGE_BORDER_CLR_EN
        frame_mixed();
        run_table();
        drain();
        cmp("t6_count", edge_count_o, 11);
`else
        for (int i = 0; i < NPIX; i++) add(1, 120, 100, 50, i == 5 || i == 6, CLS_STRONG);
        run_table();
        drain();
        cmp("t6_border_count", edge_count_o, 2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
